// File: rtl/relu_fwd_stream.sv
// relu_fwd_stream
//   Streaming forward ReLU stage. Each accepted Q8.8 element is emitted one
//   cycle later as max(0,x). A derivative-mask bit (1 when x >= 0) is recorded
//   per element, and the packed mask is published at the end of each vector.
//
//   Optional feature (compile-time macro RELU_LEAKY_EN):
//     defined   - negative inputs emit x >>> 3 (leaky slope 1/8)
//     undefined - negative inputs emit 0
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready              upstream handshake
//   in_data, in_last               pre-activation element, end-of-vector marker
//   out_valid/out_ready            downstream handshake
//   out_data, out_last             activated element, end-of-vector marker
//   mask_valid, mask               one-cycle pulse with the packed vector mask
//   len_err                        sticky framing error
module relu_fwd_stream #(
  parameter int NBITS   = 16,
  parameter int VEC_LEN = 8,
  parameter int IDX_W   = $clog2(VEC_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NBITS-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NBITS-1:0]   out_data,
  output logic               out_last,
  output logic               mask_valid,
  output logic [VEC_LEN-1:0] mask,
  output logic               len_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  logic               out_valid_q,  out_valid_d;
  logic [NBITS-1:0]   out_data_q,   out_data_d;
  logic               out_last_q,   out_last_d;
  logic               mask_valid_q, mask_valid_d;
  logic [VEC_LEN-1:0] mask_q,       mask_d;
  logic               len_err_q,    len_err_d;
  logic [IDX_W-1:0]   idx_q,        idx_d;
  logic [VEC_LEN-1:0] acc_q,        acc_d;
  logic               accept;

  // Combinational ready lets a consumed slot be refilled in the same cycle.
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    mask_valid_d = 1'b0;
    mask_d       = mask_q;
    len_err_d    = len_err_q;
    idx_d        = idx_q;
    acc_d        = acc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      if (in_data[NBITS-1]) begin
`ifdef RELU_LEAKY_EN
        out_data_d = NBITS'($signed(in_data) >>> 3);
`else
        out_data_d = '0;
`endif
      end else begin
        out_data_d = in_data;
      end

      // The current bit is written first so a completing vector publishes it.
      acc_d[idx_q] = ~in_data[NBITS-1];

      if (idx_q == LAST_IDX) begin
        idx_d = '0;
        if (in_last) begin
          mask_d       = acc_d;
          mask_valid_d = 1'b1;
        end else begin
          len_err_d = 1'b1;
        end
        acc_d = '0;
      end else if (in_last) begin
        idx_d     = '0;
        acc_d     = '0;
        len_err_d = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      mask_valid_q <= 1'b0;
      mask_q       <= '0;
      len_err_q    <= 1'b0;
      idx_q        <= '0;
      acc_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      mask_valid_q <= mask_valid_d;
      mask_q       <= mask_d;
      len_err_q    <= len_err_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign mask_valid = mask_valid_q;
  assign mask       = mask_q;
  assign len_err    = len_err_q;

endmodule

// File: doc/relu_fwd_stream.md
Name: relu_fwd_stream

Overview:
- Streaming forward-pass ReLU stage for the autoencoder datapath. Consumes Q8.8 signed pre-activations element-by-element over a valid/ready handshake and emits max(0,x).
- Also records one derivative-mask bit per element: 1 when the element is >= 0, 0 when it is negative.
- At the end of each vector it publishes the packed mask. The backward pass consumes this mask instead of recomputing the derivative.

Parameters:
- NBITS, 16, data width (signed two's complement, Q8.8).
- VEC_LEN, 8, elements per vector; must be >= 2.
- IDX_W, $clog2(VEC_LEN), width of the element counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  stage can accept an element this cycle.
- in_data  input  NBITS  pre-activation value, signed Q8.8.
- in_last  input  1  marks the final element of a vector.
- out_valid  output  1  out_data holds a valid element.
- out_ready  input  1  downstream accepts the element this cycle.
- out_data  output  NBITS  activated value.
- out_last  output  1  out_data is the final element of a vector.
- mask_valid  output  1  one-cycle pulse; mask holds a complete vector mask.
- mask  output  VEC_LEN  bit i = 1 when element i was >= 0.
- len_err  output  1  sticky framing error flag.

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge. All of the following clear to 0 on that edge, and any in-flight element or partial vector is discarded:
  - out_valid, out_data, out_last
  - mask_valid, mask
  - len_err
  - element counter idx
  - internal mask accumulator
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational, so there are no bubbles under continuous flow.
  - An element is accepted on a cycle where in_valid && in_ready.
  - out_data and out_last are held stable while out_valid && !out_ready.
- Latency: exactly 1 cycle. An element accepted at edge N is presented with out_valid=1 after edge N.
- On accept:
  - out_data <= in_data[NBITS-1] ? 0 : in_data. Zero is passed through unchanged.
  - acc[idx] <= ~in_data[NBITS-1].
  - out_last <= in_last.
- Counter: idx increments on each accept.
  - Accept at idx==VEC_LEN-1 with in_last=1 (normal end of vector):
    - idx wraps to 0.
    - mask <= final accumulator value, including the current bit.
    - mask_valid pulses for 1 cycle, in the same cycle out_valid rises for that last element.
    - Accumulator clears.
  - Framing errors set len_err=1, which stays sticky until reset:
    - in_last=1 at idx<VEC_LEN-1: idx resets to 0, accumulator clears, no mask_valid pulse. The element itself is still forwarded with out_last=1.
    - in_last=0 at idx==VEC_LEN-1: idx wraps to 0, accumulator clears, no mask_valid pulse.
- Mask hold and priority:
  - mask holds its value until the next complete vector. It does not wait for a consumer handshake.
  - mask_valid is independent of out_ready.
- Backpressure: while out_valid && !out_ready, in_ready=0; no accept happens and idx is frozen.
- Simultaneous events: when the output is consumed and a new element is accepted in the same cycle, the output register reloads with the new element and out_valid stays 1.
- No arithmetic widening is performed: the output width equals the input width, and no saturation is needed.

Optional Feature:
- Macro RELU_LEAKY_EN.
- Defined: negative inputs produce out_data = in_data >>> 3 (arithmetic shift, slope 1/8). Mask bits are unchanged (1 only when the element is >= 0).
- Undefined: negative inputs produce 0. No shifter logic is synthesized.

Test Plan:
- Reset mid-vector:
  - Stimulus: accept 3 elements, assert rst_n=0 for 1 cycle, then send a full 8-element vector.
  - Required response: out_valid=0 after reset; the first mask pulse reflects only the new vector; len_err=0.
- Mixed-sign vector, continuous flow, out_ready=1:
  - Stimulus: in_data = 0x0100, 0xFF00, 0x0000, 0x8000, 0x7FFF, 0xFFFF, 0x0280, 0xFE00, with in_last on element 7.
  - Required response: outputs 0x0100, 0, 0, 0, 0x7FFF, 0, 0x0280, 0, each 1 cycle after input; mask=8'b0101_0101 (bit0=element0); single mask_valid pulse coincident with out_last; in_ready never drops.
- Backpressure:
  - Stimulus: hold out_ready=0 for 4 cycles mid-vector while in_valid=1.
  - Required response: in_ready=0; out_data stable; idx frozen; no element lost or duplicated once out_ready=1.
- Early last:
  - Stimulus: in_last=1 on element 5.
  - Required response: len_err=1 (sticky), no mask_valid; the next 8-element vector produces a correct mask pulse.
- Missing last:
  - Stimulus: in_last=0 on element 7.
  - Required response: len_err=1; no mask_valid; idx wraps to 0.
- RELU_LEAKY_EN defined:
  - Stimulus: in_data=0xF800 (-8.0).
  - Required response: out_data=0xFF00 (-1.0); mask bit=0.
